// File: rtl/riscv_div_arb_pkg.sv
// riscv_div_arb_pkg
// Shared definitions for the two-core divider arbiter: the control FSM state
// encoding and the default watchdog length used by riscv_div_arbiter.
package riscv_div_arb_pkg;

    // Default number of cycles a divide may spend between issue and writeback
    // before the arbiter gives up on it and reports a timeout.
    localparam int WDOG_CYCLES_DEFAULT = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// riscv_rr_arb2
// Two-way round-robin grant. A lone requester is always granted; when both
// request, the one that was not granted last wins. The priority pointer only
// moves when a grant is actually issued.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (pointer favours requester 0)
//   en_i     : grants may be issued this cycle
//   req_i    : request vector, bit n = requester n
//   grant_o  : one-hot (or zero) grant vector, combinational
module riscv_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    // ptr_q names the requester that wins a tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = req_i;
            end
        end
    end

    // After granting a requester, the tie goes to the other one next time.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/riscv_div_arbiter.sv
// riscv_div_arbiter
// Shares one iterative divider between two cores. A request is accepted in
// IDLE, issued to the divider for one cycle, then the arbiter waits for the
// writeback (or a watchdog expiry) and returns the result to the owning core.
// A core may flush its outstanding divide; the divider still runs to
// completion but the response is swallowed.
//
// Ports
//   clk_i, rst_i                        : clock / async active-high reset
//   reqN_valid_i, reqN_opcode_i,
//   reqN_ra_operand_i, reqN_rb_operand_i,
//   reqN_rd_idx_i                       : divide request from core N
//   reqN_accept_o                       : request taken this cycle
//   reqN_flush_i                        : core N discards its outstanding divide
//   respN_valid_o, respN_value_o,
//   respN_rd_idx_o, respN_timeout_o     : result returned to core N
//   div_valid_o, div_opcode_o,
//   div_ra_operand_o, div_rb_operand_o,
//   div_rd_idx_o                        : issue port towards the divider
//   div_wb_valid_i, div_wb_value_i      : writeback from the divider
module riscv_div_arbiter
    import riscv_div_arb_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_ra_operand_i,
    input  logic [31:0] req0_rb_operand_i,
    input  logic [4:0]  req0_rd_idx_i,
    output logic        req0_accept_o,
    input  logic        req0_flush_i,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_value_o,
    output logic [4:0]  resp0_rd_idx_o,
    output logic        resp0_timeout_o,
    input  logic        req1_valid_i,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_ra_operand_i,
    input  logic [31:0] req1_rb_operand_i,
    input  logic [4:0]  req1_rd_idx_i,
    output logic        req1_accept_o,
    input  logic        req1_flush_i,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_value_o,
    output logic [4:0]  resp1_rd_idx_o,
    output logic        resp1_timeout_o,
    output logic        div_valid_o,
    output logic [31:0] div_opcode_o,
    output logic [31:0] div_ra_operand_o,
    output logic [31:0] div_rb_operand_o,
    output logic [4:0]  div_rd_idx_o,
    input  logic        div_wb_valid_i,
    input  logic [31:0] div_wb_value_i
);

    localparam int CntW = $clog2(WDOG_CYCLES + 1);

    arb_state_e        state_q,   state_d;
    logic [31:0]       opcode_q,  opcode_d;
    logic [31:0]       ra_q,      ra_d;
    logic [31:0]       rb_q,      rb_d;
    logic [4:0]        rdIdx_q,   rdIdx_d;
    logic              owner_q,   owner_d;
    logic              dropped_q, dropped_d;
    logic [CntW-1:0]   wdogCnt_q, wdogCnt_d;
    logic [31:0]       result_q,  result_d;
    logic              timeout_q, timeout_d;
    logic [1:0][31:0]  holdValue_q, holdValue_d;
    logic [1:0][4:0]   holdRdIdx_q, holdRdIdx_d;

    logic [1:0] grant;
    logic [1:0] respValid;
    logic       ownerFlush;
    logic       arbEn;

    // Accepts are also masked while reset is held so nothing is granted
    // before the FSM is released.
    assign arbEn = (state_q == ST_IDLE) && !rst_i;

    riscv_rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arbEn),
        .req_i   ({req1_valid_i, req0_valid_i}),
        .grant_o (grant)
    );

    assign req0_accept_o = grant[0];
    assign req1_accept_o = grant[1];

    assign ownerFlush = owner_q ? req1_flush_i : req0_flush_i;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rdIdx_d   = rdIdx_q;
        owner_d   = owner_q;
        dropped_d = dropped_q;
        wdogCnt_d = wdogCnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d   = grant[1];
                    opcode_d  = grant[1] ? req1_opcode_i     : req0_opcode_i;
                    ra_d      = grant[1] ? req1_ra_operand_i : req0_ra_operand_i;
                    rb_d      = grant[1] ? req1_rb_operand_i : req0_rb_operand_i;
                    rdIdx_d   = grant[1] ? req1_rd_idx_i     : req0_rd_idx_i;
                    dropped_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ownerFlush) begin
                    dropped_d = 1'b1;
                end
                wdogCnt_d = CntW'(1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ownerFlush) begin
                    dropped_d = 1'b1;
                end
                // A writeback in the expiry cycle still wins over the timeout.
                if (div_wb_valid_i) begin
                    result_d  = div_wb_value_i;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (wdogCnt_q == CntW'(WDOG_CYCLES)) begin
                    result_d  = 32'd0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wdogCnt_d = wdogCnt_q + CntW'(1);
                end
            end
            ST_RESP: begin
                wdogCnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A flush arriving in the response cycle itself also suppresses delivery.
    assign respValid[0] = (state_q == ST_RESP) && !dropped_q && !owner_q && !req0_flush_i;
    assign respValid[1] = (state_q == ST_RESP) && !dropped_q &&  owner_q && !req1_flush_i;

    always_comb begin
        holdValue_d = holdValue_q;
        holdRdIdx_d = holdRdIdx_q;
        for (int n = 0; n < 2; n++) begin
            if (respValid[n]) begin
                holdValue_d[n] = result_q;
                holdRdIdx_d[n] = rdIdx_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rdIdx_q     <= '0;
            owner_q     <= 1'b0;
            dropped_q   <= 1'b0;
            wdogCnt_q   <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            holdValue_q <= '0;
            holdRdIdx_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rdIdx_q     <= rdIdx_d;
            owner_q     <= owner_d;
            dropped_q   <= dropped_d;
            wdogCnt_q   <= wdogCnt_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            holdValue_q <= holdValue_d;
            holdRdIdx_q <= holdRdIdx_d;
        end
    end

    assign div_valid_o      = (state_q == ST_ISSUE);
    assign div_opcode_o     = opcode_q;
    assign div_ra_operand_o = ra_q;
    assign div_rb_operand_o = rb_q;
    assign div_rd_idx_o     = rdIdx_q;

    assign resp0_valid_o   = respValid[0];
    assign resp0_value_o   = respValid[0] ? result_q : holdValue_q[0];
    assign resp0_rd_idx_o  = respValid[0] ? rdIdx_q  : holdRdIdx_q[0];
    assign resp0_timeout_o = respValid[0] & timeout_q;
    assign resp1_valid_o   = respValid[1];
    assign resp1_value_o   = respValid[1] ? result_q : holdValue_q[1];
    assign resp1_rd_idx_o  = respValid[1] ? rdIdx_q  : holdRdIdx_q[1];
    assign resp1_timeout_o = respValid[1] & timeout_q;

endmodule
